// File: rtl/lsp_scalar_encoder_pkg.sv
// Shared constants, tables and FSM encoding for the LSP scalar encoder.
package lsp_pkg;

    localparam int LSP_ORDER  = 10;
    localparam int LSP_BITS_W = 36;

    // 4000/pi in Q16.16: converts an LSP in radians to Hz at 8 kHz sampling.
    localparam logic [31:0] RADTOHZ = 32'h04F93D52;

    // Bits per LSP index; element 0 is the first LSP of the frame.
    localparam logic [LSP_ORDER-1:0][2:0] BITS_TAB = {
        3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4
    };

    // Codebook size per order, always 2^BITS_TAB[i].
    localparam logic [LSP_ORDER-1:0][4:0] M_TAB = {
        5'd4, 5'd8, 5'd8, {7{5'd16}}
    };

    // LSB position of each field inside lsp_bits (order 0 sits at the top).
    localparam logic [LSP_ORDER-1:0][5:0] OFS_TAB = {
        6'd0, 6'd2, 6'd5, 6'd8, 6'd12, 6'd16, 6'd20, 6'd24, 6'd28, 6'd32
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_MULT,
        S_QSTART,
        S_QWAIT,
        S_STORE,
        S_FIN
    } lsp_state_e;

    // Mask covering a field of width w starting at bit ofs.
    function automatic logic [LSP_BITS_W-1:0] field_mask(input logic [2:0] w,
                                                         input logic [5:0] ofs);
        return ((LSP_BITS_W'(1) << w) - LSP_BITS_W'(1)) << ofs;
    endfunction

endpackage

// File: rtl/lsp_scalar_encoder_qmult.sv
// Signed fixed-point multiplier: y = a * b with Q fractional bits, truncated.
module qmult #(
    parameter int Q = 16,
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    logic signed [2*N-1:0] a_ext;
    logic signed [2*N-1:0] b_ext;
    logic signed [2*N-1:0] prod;

    // Sign-extend, multiply at full width, then drop the Q fraction LSBs.
    always_comb begin
        a_ext = {{N{a[N-1]}}, a};
        b_ext = {{N{b[N-1]}}, b};
        prod  = a_ext * b_ext;
        y     = N'(prod >>> Q);
    end

endmodule

// File: rtl/lsp_scalar_encoder.sv
// Walks the LSPs of a frame: reads each from RAM, converts rad->Hz, hands it
// to the external quantiser and packs the returned indexes MSB-first.
//
// Quantiser handshake: q_start is a level request that is high in every
// active state of an order and drops for exactly the STORE cycle, so the
// quantiser sees one low cycle between orders. q_done is only accepted in
// QWAIT; q_index is captured in that same cycle and written in STORE.
module lsp_scalar_encoder #(
    parameter int N         = 32,
    parameter int Q         = 16,
    parameter int LSP_ORDER = lsp_pkg::LSP_ORDER
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [3:0]   lsp_addr,
    input  logic [N-1:0] lsp_rdata,
    output logic         q_start,
    output logic [3:0]   q_order,
    output logic [4:0]   q_m,
    output logic [N-1:0] q_lsp_hz,
    input  logic [4:0]   q_index,
    input  logic         q_done,
    output logic [35:0]  lsp_bits,
    output logic         busy,
    output logic         done
);
    import lsp_pkg::*;

    localparam logic [3:0] LAST_I = 4'(LSP_ORDER - 1);

    lsp_state_e       state_q, state_d;
    logic [3:0]       i_q, i_d;
    logic [3:0]       lsp_addr_q, lsp_addr_d;
    logic [N-1:0]     lsp_q, lsp_d;
    logic             q_start_q, q_start_d;
    logic [3:0]       q_order_q, q_order_d;
    logic [4:0]       q_m_q, q_m_d;
    logic [N-1:0]     q_lsp_hz_q, q_lsp_hz_d;
    logic [4:0]       q_idx_q, q_idx_d;
    logic [35:0]      lsp_bits_q, lsp_bits_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     hz;
    logic [35:0]      fmask;

    qmult #(.Q(Q), .N(N)) u_qmult (
        .a (N'(RADTOHZ)),
        .b (lsp_q),
        .y (hz)
    );

    // Next-state logic and datapath updates; registered outputs follow state_d.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        lsp_addr_d = lsp_addr_q;
        lsp_d      = lsp_q;
        q_order_d  = q_order_q;
        q_m_d      = q_m_q;
        q_lsp_hz_d = q_lsp_hz_q;
        q_idx_d    = q_idx_q;
        lsp_bits_d = lsp_bits_q;
        fmask      = field_mask(BITS_TAB[i_q], OFS_TAB[i_q]);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ADDR;
                    i_d        = '0;
                    lsp_addr_d = '0;
                    lsp_bits_d = '0;
                end
            end
            S_ADDR:  state_d = S_READ;
            S_READ:  state_d = S_MULT;
            S_MULT: begin
                lsp_d   = lsp_rdata;
                state_d = S_QSTART;
            end
            S_QSTART: begin
                q_lsp_hz_d = hz;
                q_order_d  = i_q;
                q_m_d      = M_TAB[i_q];
                state_d    = S_QWAIT;
            end
            S_QWAIT: begin
                if (q_done) begin
                    q_idx_d = q_index;
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                lsp_bits_d = (lsp_bits_q & ~fmask) |
                             ((36'(q_idx_q) << OFS_TAB[i_q]) & fmask);
                if (i_q == LAST_I) begin
                    state_d = S_FIN;
                end else begin
                    i_d        = i_q + 4'd1;
                    lsp_addr_d = i_q + 4'd1;
                    state_d    = S_ADDR;
                end
            end
            S_FIN: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        q_start_d = (state_d == S_ADDR) || (state_d == S_READ) || (state_d == S_MULT) ||
                    (state_d == S_QSTART) || (state_d == S_QWAIT);
        busy_d    = q_start_d || (state_d == S_STORE);
        done_d    = (state_d == S_FIN);
    end

    // State and output registers, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            lsp_addr_q <= '0;
            lsp_q      <= '0;
            q_start_q  <= 1'b0;
            q_order_q  <= '0;
            q_m_q      <= '0;
            q_lsp_hz_q <= '0;
            q_idx_q    <= '0;
            lsp_bits_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            lsp_addr_q <= lsp_addr_d;
            lsp_q      <= lsp_d;
            q_start_q  <= q_start_d;
            q_order_q  <= q_order_d;
            q_m_q      <= q_m_d;
            q_lsp_hz_q <= q_lsp_hz_d;
            q_idx_q    <= q_idx_d;
            lsp_bits_q <= lsp_bits_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign lsp_addr = lsp_addr_q;
    assign q_start  = q_start_q;
    assign q_order  = q_order_q;
    assign q_m      = q_m_q;
    assign q_lsp_hz = q_lsp_hz_q;
    assign lsp_bits = lsp_bits_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/lsp_scalar_encoder.md
LSP_SCALAR_ENCODER -- requirements
Module: lsp_scalar_encoder

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning data word width.
REQ-002 The block SHALL have parameter Q, default 16, meaning fractional bits of the signed fixed-point format.
REQ-003 The block SHALL have parameter LSP_ORDER, default 10, meaning the number of LSPs per frame.
REQ-004 The block SHALL have port clk, input, 1, the system clock.
REQ-005 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, frame encode request (level).
REQ-007 The block SHALL have port lsp_addr, output, 4, LSP RAM read address.
REQ-008 The block SHALL have port lsp_rdata, input, N, LSP in radians (Q16.16), valid 2 cycles after lsp_addr changes.
REQ-009 The block SHALL have port q_start, output, 1, quantiser run request (level).
REQ-010 The block SHALL have port q_order, output, 4, LSP order index i to the quantiser.
REQ-011 The block SHALL have port q_m, output, 5, codebook size for order i.
REQ-012 The block SHALL have port q_lsp_hz, output, N, LSP in Hz (Q16.16) to the quantiser.
REQ-013 The block SHALL have port q_index, input, 5, best codebook index from the quantiser.
REQ-014 The block SHALL have port q_done, input, 1, quantiser result valid.
REQ-015 The block SHALL have port lsp_bits, output, 36, packed LSP indexes.
REQ-016 The block SHALL have port busy, output, 1, encode in progress.
REQ-017 The block SHALL have port done, output, 1, lsp_bits valid.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, READ, MULT, QSTART, QWAIT, STORE and FIN.
- IDLE->ADDR when start=1; i cleared, busy set.
- ADDR drives lsp_addr=i.
- READ waits one cycle.
- MULT latches lsp_rdata.
- QSTART registers q_lsp_hz = RADTOHZ*lsp (qmult, Q16.16, truncated); q_order=i; q_m per table.
- QWAIT holds q_start=1 until q_done=1.
REQ-019 In STORE the block SHALL write q_index, truncated to bits[i], into its field, drive q_start=0 for exactly one cycle, then go to ADDR with i+1, or to FIN if i=LSP_ORDER-1.
REQ-020 Bit widths bits[i] SHALL be 4,4,4,4,4,4,4,3,3,2 and q_m SHALL equal 2^bits[i] (16/8/4).
REQ-021 Packing SHALL be MSB-first: index 0 in lsp_bits[35:32], ..., index 6 in [11:8], index 7 in [7:5], index 8 in [4:2], index 9 in [1:0].
REQ-022 In FIN, done SHALL equal 1, busy SHALL equal 0 and lsp_bits SHALL hold stable; the FSM SHALL return to IDLE when start=0, clearing done.
REQ-023 start SHALL be ignored while busy=1 or in FIN.
REQ-024 q_done arriving in any state other than QWAIT SHALL be ignored.
REQ-025 Per-order latency SHALL be 5 cycles plus the QWAIT duration; q_done in the first QWAIT cycle gives 6 cycles per order.
REQ-026 lsp_bits SHALL be cleared on entry to ADDR from IDLE.

Reset
REQ-027 On rst=0 the FSM SHALL enter IDLE asynchronously, and i, lsp_addr, q_start, q_order, q_m, q_lsp_hz, lsp_bits, busy and done SHALL all be 0.
REQ-028 Reset mid-frame SHALL abort the encode; no partial lsp_bits SHALL be retained.
REQ-029 Encoding after release SHALL restart only on a fresh start=1.

Structure
REQ-030 The shared package lsp_pkg SHALL hold RADTOHZ = 32'h04F93D52 (4000/pi, Q16.16), LSP_ORDER, the bits[] table, the m[] table and the FSM state encoding.
REQ-031 The block SHALL use one sub-module, the existing qmult #(Q,N) fixed-point multiplier, for the rad->Hz conversion.
REQ-032 The quantiser and LSP RAM SHALL be external.

Verification
REQ-033 The bench SHALL load RAM[0..9]=32'h00008000 (0.5 rad) and use a stub quantiser returning q_index=q_order after 3 cycles -> each q_lsp_hz=32'h027C9EA9, q_m sequence 16x7, 8, 8, 4, and lsp_bits=36'h0123456E1 with done=1.
REQ-034 The bench SHALL apply a stub quantiser that returns q_done in the first QWAIT cycle -> 60 cycles from the first ADDR to FIN, and q_start low for exactly 1 cycle between orders.
REQ-035 The bench SHALL drive rst=0 while i=5 in QWAIT -> all outputs 0 immediately; after release with start=1, a full correct frame.
REQ-036 The bench SHALL pulse start during busy and keep start high through FIN -> no restart; done stays 1 until start=0, then the FSM returns to IDLE with done=0.
REQ-037 The bench SHALL have the stub return q_index=5'd31 for all orders -> lsp_bits=36'hFFFFFFFFF (truncation).
REQ-038 The bench SHALL inject a spurious q_done in READ -> ignored, lsp_bits unchanged versus the reference run.
